// File: rtl/pcache_pkg.sv
// Shared sizes, state encodings and the null-program id for the program cache controller.
package pcache_pkg;
  localparam int ADDRESS_WIDTH = 15;
  localparam int LOOP_CNT      = 4;
  localparam int APU_CNT       = 4;
  // Two values per loop (start/end); 27 configuration values per APU.
  localparam int LOOP_VALS     = 2 * LOOP_CNT;
  localparam int APU_VALS      = 27 * APU_CNT;
  localparam int LOOP_W        = LOOP_VALS * ADDRESS_WIDTH;
  localparam int APU_W         = APU_VALS * ADDRESS_WIDTH;
  localparam int PROG_W        = 8;

  localparam logic [PROG_W-1:0] NULL_PROG = '0;

  typedef enum logic [1:0] {R_IDLE, R_RD0, R_RD1, R_OUT} rd_state_t;
  typedef enum logic {W_IDLE, W_HI} wr_state_t;
endpackage

// File: rtl/pcache_write_seq.sv
// Loader write sequencer: low half then high half of one program, two cycles per program.
module pcache_write_seq import pcache_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [PROG_W-1:0] wr_prog,
  input  logic              rd_block,
  output logic              wr_ready,
  output logic              wr_active,
  output logic [PROG_W-1:0] wr_busy_prog,
  output logic              wr_in_hi,
  output logic [PROG_W-1:0] mem_loop_write_prog_addr,
  output logic [PROG_W-1:0] mem_apu_write_prog_addr,
  output logic              mem_loop_we_pos,
  output logic              mem_apu_we_pos
);
  wr_state_t state;
  logic      start;

  assign start = !reset && (state == W_IDLE) && wr_valid && (wr_prog != NULL_PROG) && !rd_block;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= W_IDLE;
    end else if (start) begin
      state <= W_HI;
    end else if (state == W_HI) begin
      state <= W_IDLE;
    end
  end

  assign wr_in_hi     = (state == W_HI);
  assign wr_active    = start || wr_in_hi;
  assign wr_busy_prog = wr_active ? wr_prog : NULL_PROG;
  // Program 0 is never stored; acknowledge it straight away.
  assign wr_ready     = !reset && (wr_in_hi || ((state == W_IDLE) && wr_valid && (wr_prog == NULL_PROG)));

  // Idle cycles park both write ports on the program-0 sink.
  assign mem_loop_write_prog_addr = wr_busy_prog;
  assign mem_apu_write_prog_addr  = wr_busy_prog;
  assign mem_loop_we_pos          = wr_in_hi;
  assign mem_apu_we_pos           = wr_in_hi;
endmodule

// File: rtl/pcache_ctrl.sv
// Program-cache sequencer: arbitrates descriptor fetches and loader writes onto ro_data_mem.
// Fetch data appears three cycles after accept; writes never race a read of the same program.
module pcache_ctrl #(
  parameter int  ADDRESS_WIDTH = pcache_pkg::ADDRESS_WIDTH,
  parameter int  LOOP_VALS     = pcache_pkg::LOOP_VALS,
  parameter int  APU_VALS      = pcache_pkg::APU_VALS,
  localparam int LOOP_W        = LOOP_VALS * ADDRESS_WIDTH,
  localparam int APU_W         = APU_VALS * ADDRESS_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [7:0]        fetch_prog,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_prog,
  output logic [LOOP_W-1:0] out_loop_data,
  output logic [APU_W-1:0]  out_apu_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_prog,
  input  logic [LOOP_W-1:0] wr_loop_data,
  input  logic [APU_W-1:0]  wr_apu_data,
  output logic              mem_reset_read,
  output logic [7:0]        mem_read_prog_addr,
  input  logic [LOOP_W-1:0] mem_loop_read_data,
  input  logic [APU_W-1:0]  mem_apu_read_data,
  output logic [7:0]        mem_loop_write_prog_addr,
  output logic [7:0]        mem_apu_write_prog_addr,
  output logic              mem_loop_we_pos,
  output logic              mem_apu_we_pos,
  output logic [LOOP_W-1:0] mem_loop_write_data,
  output logic [APU_W-1:0]  mem_apu_write_data
);
  import pcache_pkg::*;

  rd_state_t         rd_state;
  logic [PROG_W-1:0] held_prog;
  logic              rd_busy;
  logic              rd_block;
  logic              fetch_conflict;
  logic              accept;
  logic              wr_active;
  logic              wr_in_hi;
  logic [PROG_W-1:0] wr_busy_prog;

  assign rd_busy  = (rd_state != R_IDLE);
  assign rd_block = rd_busy && (wr_prog == held_prog);

  pcache_write_seq u_write_seq (
    .clk                      (clk),
    .reset                    (reset),
    .wr_valid                 (wr_valid),
    .wr_prog                  (wr_prog),
    .rd_block                 (rd_block),
    .wr_ready                 (wr_ready),
    .wr_active                (wr_active),
    .wr_busy_prog             (wr_busy_prog),
    .wr_in_hi                 (wr_in_hi),
    .mem_loop_write_prog_addr (mem_loop_write_prog_addr),
    .mem_apu_write_prog_addr  (mem_apu_write_prog_addr),
    .mem_loop_we_pos          (mem_loop_we_pos),
    .mem_apu_we_pos           (mem_apu_we_pos)
  );

  // A write starting this cycle also holds off a same-program fetch so the fetch sees new data.
  assign fetch_conflict = wr_active && (fetch_prog == wr_busy_prog);
  assign fetch_ready    = !reset && !fetch_conflict &&
                          ((rd_state == R_IDLE) || ((rd_state == R_OUT) && out_ready));
  assign accept         = fetch_valid && fetch_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state  <= R_IDLE;
      held_prog <= NULL_PROG;
    end else if (accept) begin
      rd_state  <= R_RD0;
      held_prog <= fetch_prog;
    end else begin
      case (rd_state)
        R_RD0:   rd_state <= R_RD1;
        R_RD1:   rd_state <= R_OUT;
        R_OUT:   if (out_ready) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign mem_reset_read     = reset || accept || !rd_busy;
  assign mem_read_prog_addr = accept ? fetch_prog : (rd_busy ? held_prog : NULL_PROG);

  assign out_valid     = !reset && (rd_state == R_OUT);
  assign out_prog      = held_prog;
  assign out_loop_data = (held_prog == NULL_PROG) ? '0 : mem_loop_read_data;
  assign out_apu_data  = (held_prog == NULL_PROG) ? '0 : mem_apu_read_data;

  assign mem_loop_write_data = wr_loop_data;
  assign mem_apu_write_data  = wr_apu_data;
endmodule
